// File: rtl/pll_pkg.sv
// pll_pkg: types and widths shared by the PLL front end and the loop filter
package pll_pkg;
  localparam int PLL_CUR_W = 19;
  localparam int PLL_ERR_W = 16;
  typedef enum logic [1:0] {PFD_IDLE, PFD_UP, PFD_DN, PFD_ANTIBL} pfd_state_t;
endpackage

// File: rtl/pfd_charge_pump_if.sv
// pfd_charge_pump_if: reference/feedback inputs and pump/status outputs of the PFD
interface pfd_charge_pump_if;
  import pll_pkg::*;
  logic ref_in;
  logic fb_in;
  logic pump_en;
  logic signed [PLL_CUR_W-1:0] pump_current_real;
  logic up;
  logic dn;
  logic signed [PLL_ERR_W-1:0] phase_err;
  logic phase_err_valid;
  logic slip;
  logic locked;
  modport master (
    output ref_in, fb_in, pump_en,
    input pump_current_real, up, dn, phase_err, phase_err_valid, slip, locked
  );
  modport slave (
    input ref_in, fb_in, pump_en,
    output pump_current_real, up, dn, phase_err, phase_err_valid, slip, locked
  );
endinterface

// File: rtl/pll_lock_detect.sv
// pll_lock_detect: counts consecutive in-window phase errors and flags lock
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int LOCK_WIN = 1,
  parameter int LOCK_COUNT = 16
) (
  input logic clk,
  input logic reset,
  input logic signed [PLL_ERR_W-1:0] phase_err,
  input logic phase_err_valid,
  input logic slip,
  output logic locked
);
  localparam logic [15:0] LC = 16'(LOCK_COUNT);
  localparam logic [PLL_ERR_W:0] WIN = (PLL_ERR_W+1)'(LOCK_WIN);
  logic [15:0] lock_cnt;
  logic [PLL_ERR_W:0] mag;
  assign mag = phase_err[PLL_ERR_W-1] ? -{1'b1, phase_err} : {1'b0, phase_err};
  // a slip must drop lock in the very cycle it is reported
  assign locked = lock_cnt == LC && !slip;
  always_ff @(posedge clk or posedge reset)
    if (reset) lock_cnt <= '0;
    else if (slip) lock_cnt <= '0;
    else if (phase_err_valid) lock_cnt <= mag > WIN ? '0 : lock_cnt == LC ? lock_cnt : lock_cnt + 16'd1;
endmodule

// File: rtl/pfd_charge_pump.sv
// pfd_charge_pump: phase-frequency detector with signed digital charge pump and lock reporting
module pfd_charge_pump
  import pll_pkg::*;
#(
  parameter int I_PUMP = 2048,
  parameter int ANTI_BL = 2,
  parameter int LOCK_WIN = 1,
  parameter int LOCK_COUNT = 16
) (
  input logic clk,
  input logic reset,
  pfd_charge_pump_if.slave bus
);
  localparam logic signed [PLL_CUR_W-1:0] I_POS = PLL_CUR_W'(I_PUMP);
  localparam logic [15:0] BL_INIT = 16'(ANTI_BL > 0 ? ANTI_BL - 1 : 0);
  localparam pfd_state_t EXIT_ST = ANTI_BL > 0 ? PFD_ANTIBL : PFD_IDLE;
  pfd_state_t state, state_n;
  logic ref_q, fb_q, ref_pend, fb_pend;
  logic ref_rise, fb_rise, ref_e, fb_e;
  logic [14:0] err_cnt, err_cnt_n, err_inc;
  logic [15:0] bl_cnt, bl_cnt_n;
  logic signed [PLL_ERR_W-1:0] err_n;
  logic err_vld_n, slip_n;
  assign ref_rise = bus.ref_in & ~ref_q;
  assign fb_rise = bus.fb_in & ~fb_q;
  // pending flags are only ever set in ANTIBL and consumed in IDLE
  assign ref_e = ref_rise | ref_pend;
  assign fb_e = fb_rise | fb_pend;
  assign err_inc = err_cnt + 15'(err_cnt != '1);
  always_comb begin
    state_n = state;
    err_cnt_n = err_cnt;
    bl_cnt_n = bl_cnt;
    err_n = bus.phase_err;
    err_vld_n = 1'b0;
    slip_n = 1'b0;
    case (state)
      PFD_IDLE: begin
        if (ref_e && fb_e) begin
          state_n = EXIT_ST;
          bl_cnt_n = BL_INIT;
          err_n = '0;
          err_vld_n = 1'b1;
        end else if (ref_e || fb_e) begin
          state_n = ref_e ? PFD_UP : PFD_DN;
          err_cnt_n = 15'd1;
        end
      end
      PFD_UP, PFD_DN: begin
        if (state == PFD_UP ? fb_rise : ref_rise) begin
          state_n = EXIT_ST;
          bl_cnt_n = BL_INIT;
          err_vld_n = 1'b1;
          err_n = state == PFD_UP ? $signed({1'b0, err_cnt}) : -$signed({1'b0, err_cnt});
        end else begin
          err_cnt_n = err_inc;
          slip_n = state == PFD_UP ? ref_rise : fb_rise;
        end
      end
      default: begin
        if (bl_cnt == '0) state_n = PFD_IDLE;
        else bl_cnt_n = bl_cnt - 16'd1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= PFD_IDLE;
      ref_q <= 1'b0;
      fb_q <= 1'b0;
      ref_pend <= 1'b0;
      fb_pend <= 1'b0;
      err_cnt <= '0;
      bl_cnt <= '0;
      bus.phase_err <= '0;
      bus.phase_err_valid <= 1'b0;
      bus.slip <= 1'b0;
      bus.up <= 1'b0;
      bus.dn <= 1'b0;
      bus.pump_current_real <= '0;
    end else begin
      state <= state_n;
      ref_q <= bus.ref_in;
      fb_q <= bus.fb_in;
      ref_pend <= state == PFD_ANTIBL ? ref_pend | ref_rise : state == PFD_IDLE ? 1'b0 : ref_pend;
      fb_pend <= state == PFD_ANTIBL ? fb_pend | fb_rise : state == PFD_IDLE ? 1'b0 : fb_pend;
      err_cnt <= err_cnt_n;
      bl_cnt <= bl_cnt_n;
      bus.phase_err <= err_n;
      bus.phase_err_valid <= err_vld_n;
      bus.slip <= slip_n;
      bus.up <= state_n == PFD_UP || state_n == PFD_ANTIBL;
      bus.dn <= state_n == PFD_DN || state_n == PFD_ANTIBL;
      bus.pump_current_real <= !bus.pump_en ? '0 : state_n == PFD_UP ? I_POS : state_n == PFD_DN ? -I_POS : '0;
    end
  pll_lock_detect #(.LOCK_WIN(LOCK_WIN), .LOCK_COUNT(LOCK_COUNT)) u_lock (
    .clk(clk),
    .reset(reset),
    .phase_err(bus.phase_err),
    .phase_err_valid(bus.phase_err_valid),
    .slip(bus.slip),
    .locked(bus.locked)
  );
endmodule

// File: tb/tb_pfd_charge_pump.sv
// tb_pfd_charge_pump: directed and random edge patterns against a timestamp-based PFD model
module tb_pfd_charge_pump;
  localparam int I_PUMP = 2048;
  localparam int ANTI_BL = 2;
  localparam int LOCK_WIN = 1;
  localparam int LOCK_COUNT = 16;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  pfd_charge_pump_if bus();
  pfd_charge_pump #(.I_PUMP(I_PUMP), .ANTI_BL(ANTI_BL), .LOCK_WIN(LOCK_WIN), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // model: which signal opened the comparison, when, and until which edge rises are held back
  int m_cyc = 0;
  int m_open, m_start, m_bl_end, m_run;
  bit m_pr, m_pf, m_rp, m_fp;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_open = 0;
    m_start = 0;
    m_bl_end = -1;
    m_run = 0;
    m_pr = 0;
    m_pf = 0;
    m_rp = 0;
    m_fp = 0;
  endtask
  task automatic step(input bit r, input bit f, input bit en);
    bit rr, fr, rep, slp, bl, e_lock;
    int err, span;
    @(negedge clk);
    bus.ref_in = r;
    bus.fb_in = f;
    bus.pump_en = en;
    @(posedge clk);
    m_cyc++;
    rr = r & ~m_pr;
    fr = f & ~m_pf;
    m_pr = r;
    m_pf = f;
    rep = 0;
    slp = 0;
    err = 0;
    if (m_cyc <= m_bl_end) begin
      m_rp |= rr;
      m_fp |= fr;
    end else if (m_open == 0) begin
      rr |= m_rp;
      fr |= m_fp;
      m_rp = 0;
      m_fp = 0;
      if (rr && fr) begin
        rep = 1;
        m_bl_end = m_cyc + ANTI_BL;
      end else if (rr || fr) begin
        m_open = rr ? 1 : -1;
        m_start = m_cyc;
      end
    end else if (m_open == 1 ? fr : rr) begin
      rep = 1;
      span = m_cyc - m_start;
      err = m_open * (span > 32767 ? 32767 : span);
      m_open = 0;
      m_bl_end = m_cyc + ANTI_BL;
    end else slp = m_open == 1 ? rr : fr;
    bl = m_cyc < m_bl_end;
    e_lock = m_run >= LOCK_COUNT && !slp;
    m_run = slp ? 0 : rep ? ((err <= LOCK_WIN && err >= -LOCK_WIN) ? m_run + 1 : 0) : m_run;
    #1;
    check("pump", $signed(bus.pump_current_real), en ? m_open * I_PUMP : 0);
    check("up", int'(bus.up), int'(m_open == 1 || bl));
    check("dn", int'(bus.dn), int'(m_open == -1 || bl));
    check("valid", int'(bus.phase_err_valid), int'(rep));
    if (rep) check("phase_err", $signed(bus.phase_err), err);
    check("slip", int'(bus.slip), int'(slp));
    check("locked", int'(bus.locked), int'(e_lock));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_pump"}, $signed(bus.pump_current_real), 0);
    check({tag, "_up"}, int'(bus.up), 0);
    check({tag, "_dn"}, int'(bus.dn), 0);
    check({tag, "_err"}, $signed(bus.phase_err), 0);
    check({tag, "_valid"}, int'(bus.phase_err_valid), 0);
    check({tag, "_locked"}, int'(bus.locked), 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.ref_in = 1'b0;
    bus.fb_in = 1'b0;
    bus.pump_en = 1'b1;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    // ref leads fb by 3
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    check("lead3", $signed(bus.phase_err), 3);
    idle(4);
    // fb leads ref by 5
    step(0, 1, 1);
    idle(4);
    step(1, 0, 1);
    check("lag5", $signed(bus.phase_err), -5);
    idle(4);
    // 16 aligned comparisons reach lock
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 1);
      idle(3);
    end
    check("lock16", int'(bus.locked), 1);
    // second ref rise before fb is a slip
    step(1, 0, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    check("slip_pulse", int'(bus.slip), 1);
    check("slip_unlock", int'(bus.locked), 0);
    step(0, 0, 1);
    step(0, 1, 1);
    idle(4);
    // ref rise inside anti-backlash is held until IDLE
    step(1, 1, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    check("pend_up", int'(bus.up), 1);
    step(0, 1, 1);
    idle(4);
    // asynchronous reset in the middle of an UP pulse
    step(1, 0, 1);
    step(0, 0, 1);
    @(negedge clk);
    bus.ref_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    step(1, 0, 1);
    step(0, 1, 1);
    check("post_rst", $signed(bus.phase_err), 1);
    idle(4);
    // pump disabled: no current but error still reported
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check("pump_off_err", $signed(bus.phase_err), 2);
    idle(4);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
